// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and helpers for the UART receiver
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        RECV,
        STOP
    } uart_state_t;

    localparam int DEFAULT_PAYLOAD_BITS = 8;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchroniser for the serial input, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with break detection
module uart_rx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = 9600,
    parameter int CLK_HZ       = 48000000,
    parameter int PAYLOAD_BITS = DEFAULT_PAYLOAD_BITS,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic                    uart_rx_break,
    output logic                    uart_rx_valid,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CW = ($clog2(CYCLES_PER_BIT) < 1) ? 1 : $clog2(CYCLES_PER_BIT);
    localparam int BW = $clog2(PAYLOAD_BITS + STOP_BITS + 1);

    localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_HALF = CW'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(PAYLOAD_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    logic                    rxd_s;
    uart_state_t             state, state_nxt;
    logic [CW-1:0]           cyc, cyc_nxt;
    logic [BW-1:0]           bit_cnt, bit_nxt;
    logic [PAYLOAD_BITS-1:0] shift, shift_nxt;
    logic                    deliver;
    logic                    brk;

    uart_rx_sync u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (uart_rxd),
        .q      (rxd_s)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            cyc           <= '0;
            bit_cnt       <= '0;
            shift         <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_break <= 1'b0;
            uart_rx_data  <= '0;
        end else begin
            state         <= state_nxt;
            cyc           <= cyc_nxt;
            bit_cnt       <= bit_nxt;
            shift         <= shift_nxt;
            uart_rx_valid <= deliver;
            uart_rx_break <= brk;
            if (deliver) begin
                uart_rx_data <= shift;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cyc_nxt   = cyc + 1'b1;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        deliver   = 1'b0;
        brk       = 1'b0;

        if (!uart_rx_en) begin
            state_nxt = IDLE;
            cyc_nxt   = '0;
            bit_nxt   = '0;
        end else begin
            case (state)
                IDLE: begin
                    cyc_nxt = '0;
                    bit_nxt = '0;
                    if (!rxd_s) begin
                        state_nxt = START;
                    end
                end
                // Half a bit in: a line that has gone high again was only a glitch.
                START: begin
                    if (cyc == CYC_HALF) begin
                        cyc_nxt   = '0;
                        state_nxt = rxd_s ? IDLE : RECV;
                    end
                end
                RECV: begin
                    if (cyc == CYC_LAST) begin
                        cyc_nxt   = '0;
                        shift_nxt = {rxd_s, shift[PAYLOAD_BITS-1:1]};
                        if (bit_cnt == BIT_LAST) begin
                            bit_nxt   = '0;
                            state_nxt = STOP;
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                // The byte is delivered even with a low stop bit; only an all-zero frame is a break.
                STOP: begin
                    if (cyc == CYC_LAST) begin
                        cyc_nxt = '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_nxt   = '0;
                            state_nxt = IDLE;
                            deliver   = 1'b1;
                            brk       = (shift == '0) && !rxd_s;
                        end else begin
                            bit_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    localparam int BIT_RATE = 9600;
    localparam int CLK_HZ   = 153600;
    localparam int CPB      = 16;
    localparam int LAT      = 155;

    logic       clk = 1'b0;
    logic       resetn;
    logic       uart_rxd;
    logic       uart_rx_en;
    logic       uart_rx_break;
    logic       uart_rx_valid;
    logic [7:0] uart_rx_data;

    uart_rx #(
        .BIT_RATE     (BIT_RATE),
        .CLK_HZ       (CLK_HZ),
        .PAYLOAD_BITS (8),
        .STOP_BITS    (1)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .uart_rxd      (uart_rxd),
        .uart_rx_en    (uart_rx_en),
        .uart_rx_break (uart_rx_break),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data)
    );

    always #5 clk = ~clk;

    int cyc_no = 0;
    always @(posedge clk) cyc_no <= cyc_no + 1;

    logic [7:0] vdata[$];
    logic       vbrk[$];
    int         vcyc[$];

    always @(negedge clk) begin
        if (uart_rx_valid) begin
            vdata.push_back(uart_rx_data);
            vbrk.push_back(uart_rx_break);
            vcyc.push_back(cyc_no);
        end
    end

    int n_cmp = 0;
    int n_bad = 0;
    int t0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        vdata.delete();
        vbrk.delete();
        vcyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic slot(input logic v);
        uart_rxd = v;
        idle(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input int en_off);
        logic [9:0] f;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (i == en_off) uart_rx_en = 1'b0;
            slot(f[i]);
        end
    endtask

    initial begin
        uart_rxd   = 1'b1;
        uart_rx_en = 1'b1;
        resetn     = 1'b0;
        idle(3);
        check_eq("rst_valid", uart_rx_valid, 0);
        check_eq("rst_break", uart_rx_break, 0);
        check_eq("rst_data", uart_rx_data, 8'h00);
        resetn = 1'b1;

        idle(200);
        check_eq("idle_nvalid", vdata.size(), 0);
        check_eq("idle_data", uart_rx_data, 8'h00);

        clear_log();
        t0 = cyc_no;
        send_frame(8'hAA, 99);
        idle(2 * CPB);
        check_eq("aa_count", vdata.size(), 1);
        check_eq("aa_data", vdata.size() > 0 ? vdata[0] : 8'hxx, 8'hAA);
        check_eq("aa_break", vbrk.size() > 0 ? vbrk[0] : 1'bx, 0);
        check_eq("aa_latency", vcyc.size() > 0 ? vcyc[0] - t0 : -1, LAT);

        clear_log();
        t0 = cyc_no;
        send_frame(8'h55, 99);
        send_frame(8'hFF, 99);
        idle(2 * CPB);
        check_eq("b2b_count", vdata.size(), 2);
        check_eq("b2b_data0", vdata.size() > 1 ? vdata[0] : 8'hxx, 8'h55);
        check_eq("b2b_data1", vdata.size() > 1 ? vdata[1] : 8'hxx, 8'hFF);
        check_eq("b2b_latency", vcyc.size() > 1 ? vcyc[0] - t0 : -1, LAT);
        check_eq("b2b_spacing", vcyc.size() > 1 ? vcyc[1] - vcyc[0] : -1, 10 * CPB);

        clear_log();
        t0 = cyc_no;
        uart_rxd = 1'b0;
        idle(12 * CPB);
        check_eq("brk_count", vdata.size(), 1);
        check_eq("brk_data", vdata.size() > 0 ? vdata[0] : 8'hxx, 8'h00);
        check_eq("brk_flag", vbrk.size() > 0 ? vbrk[0] : 1'bx, 1);
        check_eq("brk_latency", vcyc.size() > 0 ? vcyc[0] - t0 : -1, LAT);
        uart_rxd = 1'b1;
        idle(12 * CPB);
        resetn = 1'b0;
        idle(2);
        check_eq("rst2_data", uart_rx_data, 8'h00);
        resetn = 1'b1;
        idle(CPB);

        clear_log();
        uart_rxd = 1'b0;
        idle(CPB / 4);
        uart_rxd = 1'b1;
        idle(2 * CPB);
        check_eq("glitch_count", vdata.size(), 0);

        clear_log();
        uart_rx_en = 1'b0;
        send_frame(8'h3C, 99);
        uart_rx_en = 1'b1;
        idle(2 * CPB);
        check_eq("dis_count", vdata.size(), 0);

        clear_log();
        send_frame(8'h5A, 99);
        idle(2 * CPB);
        check_eq("5a_count", vdata.size(), 1);
        check_eq("5a_data", uart_rx_data, 8'h5A);

        clear_log();
        send_frame(8'h3C, 4);
        uart_rx_en = 1'b1;
        idle(2 * CPB);
        check_eq("abort_count", vdata.size(), 0);
        check_eq("abort_data", uart_rx_data, 8'h5A);

        clear_log();
        fork
            send_frame(8'h81, 99);
            begin
                repeat (80) @(posedge clk);
                #2 resetn = 1'b0;
                #1;
                check_eq("midrst_valid", uart_rx_valid, 0);
                check_eq("midrst_break", uart_rx_break, 0);
                check_eq("midrst_data", uart_rx_data, 8'h00);
            end
        join
        resetn = 1'b1;
        idle(2 * CPB);
        check_eq("midrst_count", vdata.size(), 0);

        clear_log();
        send_frame(8'h81, 99);
        idle(2 * CPB);
        check_eq("81_count", vdata.size(), 1);
        check_eq("81_data", vdata.size() > 0 ? vdata[0] : 8'hxx, 8'h81);
        check_eq("81_break", vbrk.size() > 0 ? vbrk[0] : 1'bx, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
